// File: rtl/hazard_flush_ctrl.sv
// Hazard/flush controller: load-use stalls and mispredict squashes for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds stall/mispredict performance counters.
module hazard_flush_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1addr_i,
  input  logic [4:0]       id_rs2addr_i,
  input  logic             id_uses_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rdaddr_i,
  input  logic             ex_branch_i,
  input  logic             ex_taken_i,
  input  logic             ex_predicted_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             pc_redirect_o,
  output logic             redirect_to_target_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam logic [1:0] LU_REM    = 2'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);
  localparam logic [1:0] FLUSH_REM = 2'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

  state_t     state_q;
  logic [1:0] rem_q;
  logic       mispredict;
  logic       load_use;

  assign mispredict = ex_branch_i & (ex_taken_i != ex_predicted_i);
  assign load_use   = ex_memread_i & (ex_rdaddr_i != 5'd0) &
                      ((ex_rdaddr_i == id_rs1addr_i) |
                       (id_uses_rs2_i & (ex_rdaddr_i == id_rs2addr_i)));

  // Outputs are combinational so ID_EX/IF_ID act on them at the same edge.
  always_comb begin
    pc_write_o           = 1'b1;
    if_id_write_o        = 1'b1;
    if_id_flush_o        = 1'b0;
    id_ex_flush_o        = 1'b0;
    pc_redirect_o        = 1'b0;
    redirect_to_target_o = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mispredict) begin
            pc_redirect_o        = 1'b1;
            redirect_to_target_o = ex_taken_i;
            if_id_flush_o        = 1'b1;
            id_ex_flush_o        = 1'b1;
          end else if (load_use) begin
            pc_write_o    = 1'b0;
            if_id_write_o = 1'b0;
            id_ex_flush_o = 1'b1;
          end
        end
        LU_STALL: begin
          pc_write_o    = 1'b0;
          if_id_write_o = 1'b0;
          id_ex_flush_o = 1'b1;
        end
        REDIRECT: begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mispredict) begin
            if (FLUSH_CYCLES > 1) begin
              state_q <= REDIRECT;
              rem_q   <= FLUSH_REM;
            end
          end else if (load_use) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_q <= LU_STALL;
              rem_q   <= LU_REM;
            end
          end
        end
        LU_STALL, REDIRECT: begin
          if (rem_q == 2'd0) state_q <= RUN;
          else               rem_q   <= rem_q - 2'd1;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if ((state_q == RUN) && mispredict)
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
